hash_cfg_axil_writer: RTL and testbench

AXI-Lite write initiator that programs the static hash table through its `cfg_axil_*` write channels. Software or a boot-time loader supplies table entries (key plus table index) on a simple valid/ready stream. The block serialises each entry into 32-bit AXI-Lite writes, issues them one at a time, and checks every write response. It sits between the configuration source and the `cfg_axil` slave port of the hash block. Its AXI-Lite address width is tied to the hash table depth.

---
 rtl/hash_cfg_axil_writer.sv | 142 ++++++++++++++
 tb/tb_hash_cfg_axil_writer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_cfg_axil_writer.sv
// hash_cfg_axil_writer: turns (key, index) table entries into a series of
// 32-bit AXI-Lite writes. Each write's response must arrive before the next
// write starts. Responses are checked and counted.
module hash_cfg_axil_writer #(
  parameter int CRC_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] entry_tkey,
  input  logic [CRC_WIDTH-1:0]  entry_tindex,
  input  logic                  entry_tvalid,
  output logic                  entry_tready,

  output logic [CRC_WIDTH+4:0]  cfg_axil_awaddr,
  output logic                  cfg_axil_awvalid,
  input  logic                  cfg_axil_awready,
  output logic [31:0]           cfg_axil_wdata,
  output logic [3:0]            cfg_axil_wstrb,
  output logic                  cfg_axil_wvalid,
  input  logic                  cfg_axil_wready,
  input  logic [1:0]            cfg_axil_bresp,
  input  logic                  cfg_axil_bvalid,
  output logic                  cfg_axil_bready,

  output logic                  busy,
  output logic [15:0]           entry_cnt,
  output logic [15:0]           err_cnt,
  output logic                  cfg_err
);

  localparam int         NWORDS    = (DATA_WIDTH + 31) / 32;
  localparam logic [1:0] LAST_WORD = 2'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP
  } state_t;

  state_t         state;
  logic [127:0]   key_ext;    // incoming key zero-padded to four words
  logic [127:0]   key_q;
  logic [CRC_WIDTH-1:0] index_q;
  logic [1:0]     word;
  logic [1:0]     word_next;
  logic           aw_fire;
  logic           w_fire;
  logic           addr_done;

  assign cfg_axil_wstrb = 4'hF;
  assign word_next      = word + 2'd1;
  assign aw_fire        = cfg_axil_awvalid && cfg_axil_awready;
  assign w_fire         = cfg_axil_wvalid && cfg_axil_wready;
  // Each valid drops after its own handshake, so a low valid while in ADDR
  // means that channel already completed for this word.
  assign addr_done      = (aw_fire || !cfg_axil_awvalid) && (w_fire || !cfg_axil_wvalid);

  // Zero-pad the key so word selection never reaches undriven bits.
  always_comb begin
    // NOTE: default first so every path assigns the whole vector; no latch.
    key_ext                   = '0;
    key_ext[DATA_WIDTH-1:0]   = entry_tkey;
  end

  // Entry FSM: capture, issue AW+W per word, wait for B, count results.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from
    // pre-edge values, independent of statement order.
    if (rst) begin
      state            <= IDLE;
      entry_tready     <= 1'b0;
      cfg_axil_awvalid <= 1'b0;
      cfg_axil_wvalid  <= 1'b0;
      cfg_axil_bready  <= 1'b0;
      cfg_axil_awaddr  <= '0;
      cfg_axil_wdata   <= '0;
      busy             <= 1'b0;
      cfg_err          <= 1'b0;
      entry_cnt        <= '0;
      err_cnt          <= '0;
      key_q            <= '0;
      index_q          <= '0;
      word             <= '0;
    end else begin
      case (state)
        IDLE: begin
          entry_tready <= 1'b1;
          if (entry_tvalid && entry_tready) begin
            key_q            <= key_ext;
            index_q          <= entry_tindex;
            word             <= 2'd0;
            cfg_axil_awaddr  <= {1'b0, entry_tindex, 2'd0, 2'b00};
            cfg_axil_wdata   <= key_ext[31:0];
            cfg_axil_awvalid <= 1'b1;
            cfg_axil_wvalid  <= 1'b1;
            entry_tready     <= 1'b0;
            busy             <= 1'b1;
            state            <= ADDR;
          end
        end

        ADDR: begin
          if (aw_fire) cfg_axil_awvalid <= 1'b0;
          if (w_fire)  cfg_axil_wvalid  <= 1'b0;
          if (addr_done) begin
            cfg_axil_bready <= 1'b1;
            state           <= RESP;
          end
        end

        RESP: begin
          if (cfg_axil_bvalid) begin
            cfg_axil_bready <= 1'b0;
            // An error is recorded but the remaining words are still written.
            if (cfg_axil_bresp != 2'b00) begin
              cfg_err <= 1'b1;
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
            if (word != LAST_WORD) begin
              word             <= word_next;
              cfg_axil_awaddr  <= {1'b0, index_q, word_next, 2'b00};
              cfg_axil_wdata   <= key_q[{word_next, 5'b00000} +: 32];
              cfg_axil_awvalid <= 1'b1;
              cfg_axil_wvalid  <= 1'b1;
              state            <= ADDR;
            end else begin
              entry_cnt    <= entry_cnt + 16'd1;
              busy         <= 1'b0;
              entry_tready <= 1'b1;
              state        <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_cfg_axil_writer.sv
// Directed bench for hash_cfg_axil_writer: a 72-bit instance driven by a
// scripted slave (skewed readies, error responses, mid-flight reset) and a
// 32-bit instance on a zero-wait slave for single-word and counter-limit runs.
module tb_hash_cfg_axil_writer;

  localparam int CW = 8;
  localparam int DW = 72;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  // Free-running cycle count used for latency checks.
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // ---------------- 72-bit instance ----------------
  logic           rst;
  logic [DW-1:0]  entry_tkey;
  logic [CW-1:0]  entry_tindex;
  logic           entry_tvalid;
  logic           entry_tready;
  logic [CW+4:0]  awaddr;
  logic           awvalid, awready;
  logic [31:0]    wdata;
  logic [3:0]     wstrb;
  logic           wvalid, wready;
  logic [1:0]     bresp;
  logic           bvalid, bready;
  logic           busy;
  logic [15:0]    entry_cnt, err_cnt;
  logic           cfg_err;

  hash_cfg_axil_writer #(.CRC_WIDTH(CW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .entry_tkey(entry_tkey), .entry_tindex(entry_tindex),
    .entry_tvalid(entry_tvalid), .entry_tready(entry_tready),
    .cfg_axil_awaddr(awaddr), .cfg_axil_awvalid(awvalid), .cfg_axil_awready(awready),
    .cfg_axil_wdata(wdata), .cfg_axil_wstrb(wstrb), .cfg_axil_wvalid(wvalid),
    .cfg_axil_wready(wready), .cfg_axil_bresp(bresp), .cfg_axil_bvalid(bvalid),
    .cfg_axil_bready(bready), .busy(busy), .entry_cnt(entry_cnt),
    .err_cnt(err_cnt), .cfg_err(cfg_err)
  );

  // ---------------- 32-bit instance, zero-wait slave ----------------
  logic           rst_s;
  logic [31:0]    entry_tkey_s;
  logic [CW-1:0]  entry_tindex_s;
  logic           entry_tvalid_s;
  logic           entry_tready_s;
  logic [CW+4:0]  awaddr_s;
  logic           awvalid_s, wvalid_s, bready_s;
  logic [31:0]    wdata_s;
  logic [3:0]     wstrb_s;
  logic [1:0]     bresp_s;
  logic           busy_s;
  logic [15:0]    entry_cnt_s, err_cnt_s;
  logic           cfg_err_s;
  logic           awready_s, wready_s, bvalid_s;

  assign awready_s = 1'b1;
  assign wready_s  = 1'b1;
  assign bvalid_s  = bready_s;

  hash_cfg_axil_writer #(.CRC_WIDTH(CW), .DATA_WIDTH(32)) dut_s (
    .clk(clk), .rst(rst_s),
    .entry_tkey(entry_tkey_s), .entry_tindex(entry_tindex_s),
    .entry_tvalid(entry_tvalid_s), .entry_tready(entry_tready_s),
    .cfg_axil_awaddr(awaddr_s), .cfg_axil_awvalid(awvalid_s), .cfg_axil_awready(awready_s),
    .cfg_axil_wdata(wdata_s), .cfg_axil_wstrb(wstrb_s), .cfg_axil_wvalid(wvalid_s),
    .cfg_axil_wready(wready_s), .cfg_axil_bresp(bresp_s), .cfg_axil_bvalid(bvalid_s),
    .cfg_axil_bready(bready_s), .busy(busy_s), .entry_cnt(entry_cnt_s),
    .err_cnt(err_cnt_s), .cfg_err(cfg_err_s)
  );

  int          n_aw_s = 0, n_w_s = 0, n_hs_s = 0;
  logic [12:0] last_awaddr_s;
  logic [31:0] last_wdata_s;
  // Record handshakes seen by the 32-bit instance's slave and entry port.
  always @(posedge clk) begin
    if (awvalid_s && awready_s) begin n_aw_s++; last_awaddr_s = awaddr_s; end
    if (wvalid_s && wready_s)   begin n_w_s++;  last_wdata_s  = wdata_s;  end
    if (entry_tvalid_s && entry_tready_s) n_hs_s++;
  end

  logic [15:0] exp_entry = '0;
  logic [15:0] exp_err   = '0;
  logic        exp_cfg   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Present one entry and hold it until accepted; scramble the inputs after.
  task automatic send_entry(input logic [DW-1:0] key, input logic [CW-1:0] idx, output int t0);
    int n = 0;
    entry_tkey   = key;
    entry_tindex = idx;
    entry_tvalid = 1'b1;
    while (!entry_tready && n < 20) begin @(posedge clk); #1; n++; end
    check("entry accepted", entry_tready, 1);
    t0 = cyc;
    @(posedge clk); #1;
    entry_tvalid = 1'b0;
    entry_tkey   = ~key;
    entry_tindex = ~idx;
    check("busy after accept", busy, 1);
    check("tready low while busy", entry_tready, 0);
  endtask

  // Slave side of one word: readies after given waits, then one B response.
  task automatic serve_word(input int aw_wait, input int w_wait, input logic [1:0] resp,
                            input logic [12:0] exp_addr, input logic [31:0] exp_data,
                            input string tag);
    int n = 0;
    bit aw_done = 0, w_done = 0, bad_payload = 0, bad_proto = 0;
    while (!awvalid && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, " awvalid"}, awvalid, 1);
    check({tag, " wvalid"}, wvalid, 1);
    n = 0;
    while (!(aw_done && w_done) && n < 40) begin
      awready = !aw_done && (n >= aw_wait);
      wready  = !w_done && (n >= w_wait);
      if (bready) bad_proto = 1;
      if (aw_done == awvalid) bad_proto = 1;
      if (w_done == wvalid)   bad_proto = 1;
      if (awvalid && awaddr !== exp_addr) bad_payload = 1;
      if (wvalid && wdata !== exp_data)   bad_payload = 1;
      if (awready && awvalid) aw_done = 1;
      if (wready && wvalid)   w_done = 1;
      @(posedge clk); #1; n++;
    end
    awready = 1'b0;
    wready  = 1'b0;
    check({tag, " payload"}, bad_payload, 0);
    check({tag, " handshake"}, bad_proto, 0);
    check({tag, " bready"}, bready, 1);
    check({tag, " valids low in RESP"}, {awvalid, wvalid}, 0);
    bvalid = 1'b1;
    bresp  = resp;
    @(posedge clk); #1;
    bvalid = 1'b0;
    bresp  = 2'b00;
  endtask

  // One three-word entry; words and base address are hand-computed by caller.
  task automatic run_entry(input logic [DW-1:0] key, input logic [CW-1:0] idx,
                           input int aw_wait, input int w_wait, input int err_word,
                           input logic [12:0] base, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2, input string tag);
    int t0;
    logic [31:0] words [3];
    words[0] = w0; words[1] = w1; words[2] = w2;
    fork
      send_entry(key, idx, t0);
      begin
        for (int w = 0; w < 3; w++)
          serve_word(aw_wait, w_wait, (w == err_word) ? 2'b10 : 2'b00,
                     base + 13'(4 * w), words[w], $sformatf("%s w%0d", tag, w));
      end
    join
    exp_entry = exp_entry + 16'd1;
    if (err_word >= 0) begin
      exp_cfg = 1'b1;
      if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    end
    check({tag, " entry_cnt"}, entry_cnt, exp_entry);
    check({tag, " err_cnt"}, err_cnt, exp_err);
    check({tag, " cfg_err"}, cfg_err, exp_cfg);
    check({tag, " busy done"}, busy, 0);
    check({tag, " tready again"}, entry_tready, 1);
    if (aw_wait == 0 && w_wait == 0) check({tag, " cycles"}, cyc - t0, 7);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n;
    rst = 1'b1; rst_s = 1'b1;
    entry_tkey = '0; entry_tindex = '0; entry_tvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    entry_tkey_s = '0; entry_tindex_s = '0; entry_tvalid_s = 1'b0; bresp_s = 2'b00;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    check("rst tready", entry_tready, 0);
    check("rst valids", {awvalid, wvalid, bready}, 0);
    check("rst busy/cfg_err", {busy, cfg_err}, 0);
    check("rst counters", {entry_cnt, err_cnt}, 0);
    check("rst awaddr", awaddr, 0);
    check("rst wdata", wdata, 0);
    check("wstrb", wstrb, 4'hF);
    rst = 1'b0;
    @(posedge clk); #1;
    check("tready after rst", entry_tready, 1);

    run_entry(72'hAB_11223344_55667788, 8'h03, 0, 0, -1, 13'h0030,
              32'h55667788, 32'h11223344, 32'h000000AB, "plan72");
    run_entry(72'h01_CAFEF00D_12345678, 8'hFF, 0, 3, -1, 13'h0FF0,
              32'h12345678, 32'hCAFEF00D, 32'h00000001, "aw_first");
    run_entry(72'hFF_FFFFFFFF_00000000, 8'h80, 3, 0, -1, 13'h0800,
              32'h00000000, 32'hFFFFFFFF, 32'h000000FF, "w_first");
    run_entry(72'h00_A5A5A5A5_5A5A5A5A, 8'h10, 1, 1, 1, 13'h0100,
              32'h5A5A5A5A, 32'hA5A5A5A5, 32'h00000000, "slverr_w1");
    run_entry(72'h12_87654321_0F0F0F0F, 8'h01, 0, 0, -1, 13'h0010,
              32'h0F0F0F0F, 32'h87654321, 32'h00000012, "sticky");

    // Reset while waiting for the first response of an entry
    send_entry(72'h33_44444444_55555555, 8'h22, t0);
    awready = 1'b1; wready = 1'b1;
    @(posedge clk); #1;
    awready = 1'b0; wready = 1'b0;
    check("midrst in RESP", bready, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst valids", {awvalid, wvalid, bready}, 0);
    check("midrst busy", busy, 0);
    check("midrst counters", {entry_cnt, err_cnt}, 0);
    check("midrst cfg_err", cfg_err, 0);
    rst = 1'b0;
    exp_entry = '0; exp_err = '0; exp_cfg = 1'b0;
    @(posedge clk); #1;
    check("midrst tready", entry_tready, 1);
    run_entry(72'h00_00000000_DEADBEEF, 8'h5A, 0, 0, -1, 13'h05A0,
              32'hDEADBEEF, 32'h00000000, 32'h00000000, "after_rst");

    // 32-bit instance: single word
    check("s rst tready", entry_tready_s, 0);
    rst_s = 1'b0;
    @(posedge clk); #1;
    check("s tready after rst", entry_tready_s, 1);
    n_aw_s = 0; n_w_s = 0;
    entry_tkey_s = 32'hDEADBEEF; entry_tindex_s = 8'h5A; entry_tvalid_s = 1'b1;
    @(posedge clk); #1;
    entry_tvalid_s = 1'b0;
    n = 0;
    while (busy_s && n < 20) begin @(posedge clk); #1; n++; end
    check("s one aw", n_aw_s, 1);
    check("s one w", n_w_s, 1);
    check("s awaddr", last_awaddr_s, 13'h05A0);
    check("s wdata", last_wdata_s, 32'hDEADBEEF);
    check("s wstrb", wstrb_s, 4'hF);
    check("s entry_cnt", entry_cnt_s, 1);
    check("s busy", busy_s, 0);

    // 65540 SLVERR entries back to back: err_cnt saturates, entry_cnt wraps
    bresp_s = 2'b10;
    n_hs_s = 0;
    n = 0;
    entry_tvalid_s = 1'b1;
    do begin @(posedge clk); #1; n++; end while (n_hs_s < 65540 && n < 250000);
    entry_tvalid_s = 1'b0;
    check("s long accepted", n_hs_s, 65540);
    n = 0;
    while (busy_s && n < 20) begin @(posedge clk); #1; n++; end
    check("s entry_cnt wrap", entry_cnt_s, 16'd5);
    check("s err_cnt sat", err_cnt_s, 16'hFFFF);
    check("s cfg_err", cfg_err_s, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
